// File: rtl/alu_sequencer_if.sv
// Command/response handshake plus the registered ALU operand bus between the
// sequencer (slave) and its environment (master: command source, ALU, consumer).
interface alu_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic             flag_clr;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_op;
  logic             alu_cin;
  logic [7:0]       alu_c;
  logic             alu_cout;
  logic             alu_alarger;
  logic             alu_equal;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [3:0]       flags;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, flag_clr, rsp_ready,
           alu_c, alu_cout, alu_alarger, alu_equal, alu_zero,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_cin,
           rsp_valid, rsp_data, flags, busy, op_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, flag_clr, rsp_ready,
           alu_c, alu_cout, alu_alarger, alu_equal, alu_zero,
    output cmd_ready, alu_a, alu_b, alu_op, alu_cin,
           rsp_valid, rsp_data, flags, busy, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state sequencer: latch a command onto the ALU operand bus, wait one
// settle cycle, capture result and flags, then hold the response until taken.
module alu_sequencer #(
  parameter int USE_FLAG_CARRY = 1,
  parameter int CNT_W          = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic             r_busy;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [2:0]       r_alu_op;
  logic             r_alu_cin;
  logic [7:0]       r_rsp_data;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_op_count;

  logic             w_accept;
  logic             w_flag_clr;
  logic             w_cin;

  assign w_accept   = bus.cmd_valid && (r_state == IDLE);
  assign w_flag_clr = bus.flag_clr && ((r_state == IDLE) || (r_state == RESP));
  // A clear arriving with the command wins over the stored carry.
  assign w_cin      = (USE_FLAG_CARRY != 0) && !w_flag_clr && r_flags[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_cin   <= 1'b0;
      r_rsp_data  <= '0;
      r_flags     <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_flag_clr) begin
        r_flags <= '0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_a     <= bus.cmd_a;
            r_alu_b     <= bus.cmd_b;
            r_alu_op    <= bus.cmd_op;
            r_alu_cin   <= w_cin;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_state <= EXEC;
        end
        EXEC: begin
          r_rsp_data  <= bus.alu_c;
          r_flags     <= {bus.alu_cout, bus.alu_alarger, bus.alu_equal, bus.alu_zero};
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
            if (r_op_count != CNT_MAX) begin
              r_op_count <= r_op_count + CNT_ONE;
            end
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.busy      = r_busy;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_cin   = r_alu_cin;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.flags     = r_flags;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 8-bit ALU attached to
// the operand bus; a narrow op_count makes saturation reachable quickly.
module tb_alu_sequencer;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset_n;

  alu_sequencer_if #(.CNT_W(CNT_W)) bus ();

  alu_sequencer #(.USE_FLAG_CARRY(1), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] sb_q[$];
  logic [3:0]  m_flags  = 4'h0;
  int          m_cnt    = 0;

  // Result packing: {cout, alarger, equal, zero, c[7:0]}
  function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    logic [8:0] s;
    logic [7:0] c;
    logic       co, ag, eq;
    s = '0; c = '0; co = 1'b0; ag = 1'b0; eq = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; c = s[7:0]; co = s[8]; end
      3'd1: begin c = {cin, a[7:1]}; co = a[0]; end
      3'd2: begin c = {a[6:0], cin}; co = a[7]; end
      3'd3: c = ~a;
      3'd4: c = a & b;
      3'd5: c = a | b;
      3'd6: c = a ^ b;
      default: begin c = a - b; co = (a < b); ag = (a > b); eq = (a == b); end
    endcase
    return {co, ag, eq, (c == 8'd0), c};
  endfunction

  always_comb begin
    {bus.alu_cout, bus.alu_alarger, bus.alu_equal, bus.alu_zero, bus.alu_c} =
      alu_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'(0));
    check({tag, "_flags"},     32'(bus.flags),     32'(0));
    check({tag, "_alu_a"},     32'(bus.alu_a),     32'(0));
    check({tag, "_alu_b"},     32'(bus.alu_b),     32'(0));
    check({tag, "_alu_op"},    32'(bus.alu_op),    32'(0));
    check({tag, "_alu_cin"},   32'(bus.alu_cin),   32'(0));
    check({tag, "_op_count"},  32'(bus.op_count),  32'(0));
    check({tag, "_busy"},      32'(bus.busy),      32'(0));
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(1));
  endtask

  // Called and returns on a falling edge with the DUT idle.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit clr_acc, input int stall, input bit clr_mid,
                        input bit clr_done, input bit ready_early,
                        output logic [7:0] got_d, output logic [3:0] got_f);
    logic        exp_cin;
    logic [11:0] e;
    int          edges;
    got_d = '0;
    got_f = '0;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'(1));
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    bus.flag_clr  = clr_acc;
    exp_cin = clr_acc ? 1'b0 : m_flags[3];
    sb_q.push_back(alu_f(op, a, b, exp_cin));
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.flag_clr = clr_mid;
    bus.cmd_a = ~a; bus.cmd_b = a ^ b; bus.cmd_op = op + 3'd1;
    if (ready_early) bus.rsp_ready = 1'b1;
    if (clr_acc) m_flags = 4'h0;
    check("busy_setup",      32'(bus.busy),      32'(1));
    check("cmd_ready_setup", 32'(bus.cmd_ready), 32'(0));
    check("alu_a",           32'(bus.alu_a),     32'(a));
    check("alu_b",           32'(bus.alu_b),     32'(b));
    check("alu_op",          32'(bus.alu_op),    32'(op));
    check("alu_cin",         32'(bus.alu_cin),   32'(exp_cin));
    check("flags_setup",     32'(bus.flags),     32'(m_flags));
    @(negedge clk);
    bus.flag_clr = 1'b0;
    check("flags_exec",     32'(bus.flags),     32'(m_flags));
    check("rsp_valid_exec", 32'(bus.rsp_valid), 32'(0));
    check("op_count_exec",  32'(bus.op_count),  32'(m_cnt));
    edges = 1;
    while (!bus.rsp_valid && edges < 8) begin
      @(negedge clk);
      edges++;
    end
    check("rsp_latency", 32'(edges), 32'(2));
    if (!bus.rsp_valid) begin
      e = sb_q.pop_front();
      bus.rsp_ready = 1'b0;
      return;
    end
    e = sb_q[0];
    check("cmd_ready_resp", 32'(bus.cmd_ready), 32'(0));
    check("op_count_resp",  32'(bus.op_count),  32'(m_cnt));
    if (stall > 0) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = 8'hA5;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("stall_rsp_valid", 32'(bus.rsp_valid), 32'(1));
        check("stall_rsp_data",  32'(bus.rsp_data),  32'(e[7:0]));
        check("stall_flags",     32'(bus.flags),     32'(e[11:8]));
        check("stall_cmd_ready", 32'(bus.cmd_ready), 32'(0));
      end
      bus.cmd_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    bus.flag_clr  = clr_done;
    e = sb_q.pop_front();
    got_d = bus.rsp_data;
    got_f = bus.flags;
    check("rsp_data", 32'(bus.rsp_data), 32'(e[7:0]));
    check("flags",    32'(bus.flags),    32'(e[11:8]));
    m_flags = clr_done ? 4'h0 : e[11:8];
    if (m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.flag_clr  = 1'b0;
    check("rsp_valid_done", 32'(bus.rsp_valid), 32'(0));
    check("cmd_ready_done", 32'(bus.cmd_ready), 32'(1));
    check("busy_done",      32'(bus.busy),      32'(0));
    check("op_count",       32'(bus.op_count),  32'(m_cnt));
    check("flags_done",     32'(bus.flags),     32'(m_flags));
    check("alu_a_hold",     32'(bus.alu_a),     32'(a));
    $display("txn op=%0d a=%02h b=%02h -> data=%02h flags=%04b count=%0d",
             op, a, b, got_d, got_f, bus.op_count);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [3:0] f;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.flag_clr = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;

    // Accepted on the very first rising edge after reset release.
    do_cmd(3'd0, 8'hF0, 8'h20, 0, 0, 0, 0, 0, d, f);
    check("add_data", 32'(d), 32'h10);
    check("add_flags", 32'(f), 32'b1000);
    do_cmd(3'd1, 8'h02, 8'h00, 0, 0, 0, 0, 0, d, f);
    check("rsh_data", 32'(d), 32'h81);
    check("rsh_flags", 32'(f), 32'b0000);
    do_cmd(3'd7, 8'h55, 8'h55, 0, 0, 0, 0, 0, d, f);
    check("cmp_eq_data", 32'(d), 32'h00);
    check("cmp_eq_flags", 32'(f), 32'b0011);
    do_cmd(3'd7, 8'h60, 8'h10, 0, 5, 0, 0, 0, d, f);
    check("cmp_gt_flags", 32'(f), 32'b0100);
    do_cmd(3'd0, 8'hF0, 8'h20, 0, 0, 1, 0, 0, d, f);
    check("add2_flags", 32'(f), 32'b1000);
    do_cmd(3'd2, 8'h80, 8'h00, 1, 0, 0, 0, 0, d, f);
    check("lsh_clr_data", 32'(d), 32'h00);
    check("lsh_clr_flags", 32'(f), 32'b1001);

    repeat (3) begin
      @(negedge clk);
      check("flags_idle_hold", 32'(bus.flags), 32'(m_flags));
    end
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    m_flags = 4'h0;
    check("flags_idle_clr", 32'(bus.flags), 32'(0));

    do_cmd(3'd0, 8'hF0, 8'h20, 0, 0, 0, 1, 1, d, f);
    check("clr_done_captured", 32'(f), 32'b1000);

    // Reset while the operation is in EXEC.
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_a = 8'h11; bus.cmd_b = 8'h22;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midop_reset");
    @(negedge clk);
    reset_n = 1'b1;
    m_flags = 4'h0;
    m_cnt   = 0;
    repeat (4) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(bus.rsp_valid), 32'(0));
      check("count_after_reset",  32'(bus.op_count),  32'(0));
    end

    for (int i = 0; i < 12; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 0, 0, d, f);
    end
    check("op_count_sat", 32'(bus.op_count), 32'(CNT_MAX));
    check("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
